// File: rtl/param_counter.sv
// Parameterised up/down counter with load, wrap or saturate at the boundary,
// terminal-count / rollover / sticky overflow flags and a hex seven-segment view.
module param_counter #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 255,
  parameter int          SATURATE  = 0,
  localparam int         DIGITS    = (WIDTH + 3) / 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  rollover,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic at_max;
  logic at_zero;
  logic at_boundary;

  assign at_max      = (count == MAX_VAL);
  assign at_zero     = (count == '0);
  assign at_boundary = up ? at_max : at_zero;
  assign tc          = enable & at_boundary;

  always_ff @(posedge clock) begin
    if (clear) begin
      count    <= '0;
      rollover <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      count    <= (load_value > MAX_VAL) ? MAX_VAL : load_value;
      rollover <= 1'b0;
      overflow <= 1'b0;
    end else if (enable) begin
      if (at_boundary) begin
        // Saturating mode leaves count untouched but still reports the event.
        rollover <= 1'b1;
        overflow <= 1'b1;
        if (SATURATE == 0) begin
          count <= up ? '0 : MAX_VAL;
        end
      end else begin
        rollover <= 1'b0;
        count    <= up ? count + ONE : count - ONE;
      end
    end else begin
      rollover <= 1'b0;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Widths that are not a multiple of four get a zero-filled top nibble.
  logic [4*DIGITS-1:0] padded;

  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = count;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign hex[7*k +: 7] = seg7(padded[4*k +: 4]);
  end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: four configurations share the stimulus
// and are each compared against an arithmetic reference model every cycle.
module tb_param_counter;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] lv = 8'd0;

  logic [7:0]  cnt0, cnt3;
  logic [3:0]  cnt1, cnt2;
  logic        tc0, tc1, tc2, tc3;
  logic        ro0, ro1, ro2, ro3;
  logic        ov0, ov1, ov2, ov3;
  logic [13:0] hex0, hex3;
  logic [6:0]  hex1, hex2;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state and the configuration of each instance.
  int mc[4];
  int mr[4];
  int mo[4];
  int pw[4]   = '{8, 4, 4, 8};
  int pmax[4] = '{255, 9, 9, 150};
  int psat[4] = '{0, 0, 1, 0};
  int glyph[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clock = ~clock;

  param_counter u0 (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv), .count(cnt0), .tc(tc0), .rollover(ro0), .overflow(ov0), .hex(hex0)
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u1 (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv[3:0]), .count(cnt1), .tc(tc1), .rollover(ro1), .overflow(ov1), .hex(hex1)
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u2 (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv[3:0]), .count(cnt2), .tc(tc2), .rollover(ro2), .overflow(ov2), .hex(hex2)
  );

  param_counter #(.WIDTH(8), .MAX_COUNT(150), .SATURATE(0)) u3 (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv), .count(cnt3), .tc(tc3), .rollover(ro3), .overflow(ov3), .hex(hex3)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_hex(input int i);
    int h = 0;
    for (int d = 0; d < (pw[i] + 3) / 4; d++) begin
      h = h | (glyph[(mc[i] >> (4 * d)) & 15] << (7 * d));
    end
    return h;
  endfunction

  function automatic int model_tc(input int i);
    if (!enable) return 0;
    return up ? int'(mc[i] == pmax[i]) : int'(mc[i] == 0);
  endfunction

  // Predict the state after the coming edge from the rules of operation.
  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      if (clear) begin
        mc[i] = 0; mr[i] = 0; mo[i] = 0;
      end else if (load) begin
        int v = int'(lv) & ((1 << pw[i]) - 1);
        mc[i] = (v > pmax[i]) ? pmax[i] : v;
        mr[i] = 0; mo[i] = 0;
      end else if (enable) begin
        if (up && mc[i] == pmax[i]) begin
          mr[i] = 1; mo[i] = 1;
          if (psat[i] == 0) mc[i] = 0;
        end else if (!up && mc[i] == 0) begin
          mr[i] = 1; mo[i] = 1;
          if (psat[i] == 0) mc[i] = pmax[i];
        end else begin
          mr[i] = 0;
          mc[i] = up ? mc[i] + 1 : mc[i] - 1;
        end
      end else begin
        mr[i] = 0;
      end
    end
  endtask

  task automatic check_dut(input int i, input int c, input int t, input int r,
                           input int o, input int h);
    check($sformatf("dut%0d_count", i), c, mc[i]);
    check($sformatf("dut%0d_tc", i), t, model_tc(i));
    check($sformatf("dut%0d_rollover", i), r, mr[i]);
    check($sformatf("dut%0d_overflow", i), o, mo[i]);
    check($sformatf("dut%0d_hex", i), h, model_hex(i));
  endtask

  task automatic check_output();
    check_dut(0, int'(cnt0), int'(tc0), int'(ro0), int'(ov0), int'(hex0));
    check_dut(1, int'(cnt1), int'(tc1), int'(ro1), int'(ov1), int'(hex1));
    check_dut(2, int'(cnt2), int'(tc2), int'(ro2), int'(ov2), int'(hex2));
    check_dut(3, int'(cnt3), int'(tc3), int'(ro3), int'(ov3), int'(hex3));
  endtask

  task automatic apply_stimulus(input logic c, input logic ld, input logic en,
                                input logic u, input logic [7:0] v);
    clear = c; load = ld; enable = en; up = u; lv = v;
    model_step();
    @(posedge clock);
    #1;
    check_output();
  endtask

  typedef struct {
    logic       clr;
    logic       ld;
    logic       en;
    logic       u;
    logic [7:0] v;
    int         exp_count;
    int         exp_roll;
    int         exp_ovf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Expected values are for the default-parameter instance.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hA6, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0, 1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h03, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 0, 0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h00, 0, 0};

    for (int i = 0; i < 4; i++) begin
      mc[i] = 0; mr[i] = 0; mo[i] = 0;
    end

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].u, vecs[i].v);
      check($sformatf("vec%0d_count", i), int'(cnt0), vecs[i].exp_count);
      check($sformatf("vec%0d_rollover", i), int'(ro0), vecs[i].exp_roll);
      check($sformatf("vec%0d_overflow", i), int'(ov0), vecs[i].exp_ovf);
    end

    $display("[TB] reset state");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("reset_hex0", int'(hex0), 14'b1000000_1000000);
    check("reset_hex1", int'(hex1), 7'b1000000);
    check("reset_tc_down", int'(tc0), 1);

    $display("[TB] free-running wrap");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 255; k++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    check("wrap_count_255", int'(cnt0), 255);
    check("wrap_tc_255", int'(tc0), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    check("wrap_count_0", int'(cnt0), 0);
    check("wrap_rollover", int'(ro0), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    check("wrap_rollover_drop", int'(ro0), 0);
    check("wrap_overflow_sticky", int'(ov0), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    check("hex_a5", int'(hex0), 14'b0001000_0010010);

    $display("[TB] decade down wrap");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("dec_count_9", int'(cnt1), 9);
    check("dec_rollover", int'(ro1), 1);
    check("dec_hex_9", int'(hex1), 7'b0010000);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("dec_count_8", int'(cnt1), 8);
    check("dec_hex_8", int'(hex1), 7'b0000000);

    $display("[TB] saturating up");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      check($sformatf("sat_count_e%0d", k), int'(cnt2), (k < 9) ? k : 9);
      check($sformatf("sat_rollover_e%0d", k), int'(ro2), int'(k >= 10));
    end
    check("sat_overflow", int'(ov2), 1);

    $display("[TB] clamped load");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("clamp_pre_overflow", int'(ov3), 1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'd200);
    check("clamp_count", int'(cnt3), 150);
    check("clamp_overflow", int'(ov3), 0);

    $display("[TB] clear beats load and enable");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
    check("clr_count", int'(cnt0), 0);
    check("clr_rollover", int'(ro0), 0);
    check("clr_overflow", int'(ov0), 0);

    $display("[TB] hold");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd42);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      check("hold_count", int'(cnt0), 42);
      check("hold_tc", int'(tc0), 0);
      check("hold_rollover", int'(ro0), 0);
    end

    $display("[TB] clear between edges");
    #2 clear = 1'b1;
    #1 check("async_clear_count", int'(cnt0), 42);
    clear = 1'b0;

    $display("[TB] random stimulus");
    for (int k = 0; k < 400; k++) begin
      apply_stimulus(($urandom_range(31) == 0), ($urandom_range(15) == 0),
                     ($urandom_range(3) != 0), 1'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
